// File: rtl/fetch_defs.sv
// Shared definitions for the instruction fetch unit: FSM encoding, fetch constants
// and the prefetch queue entry layout.
package fetch_defs;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [31:0] HALT_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned; redirect targets drop their low two bits.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: ring buffer feeding a registered head slot. count covers both the
// buffered entries and the head, so full/empty describe the whole queue.
module fetch_queue
   import fetch_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   head_valid,
   output fetch_entry_t           head_data
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     mem_count;
   logic            head_valid_q;
   fetch_entry_t    head_q;

   logic            push_acc;
   logic            pop_acc;
   logic            load;

   assign count      = mem_count + {{PW{1'b0}}, head_valid_q};
   assign full       = (count == (PW + 1)'(DEPTH));
   assign empty      = (count == '0);
   assign head_valid = head_valid_q;
   assign head_data  = head_q;

   assign push_acc = push && !full && !flush;
   assign pop_acc  = pop && head_valid_q && !flush;
   // Refill the head only from entries already buffered, never from this cycle's push.
   assign load     = (!head_valid_q || pop_acc) && (mem_count != '0) && !flush;

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // register here sees the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         mem_count    <= '0;
         head_valid_q <= 1'b0;
         head_q       <= '0;
      end else if (flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         mem_count    <= '0;
         head_valid_q <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (load) begin
            rd_ptr <= rd_ptr + 1'b1;
            head_q <= mem[rd_ptr];
         end
         mem_count <= mem_count + {{PW{1'b0}}, push_acc} - {{PW{1'b0}}, load};
         if (load)         head_valid_q <= 1'b1;
         else if (pop_acc) head_valid_q <= 1'b0;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and counts define
   // which slots are live, so stale contents are never observed.
   always_ff @(posedge clock) begin
      if (push_acc) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, fetch FSM and ROM control in front of the prefetch queue.
// Optional FETCH_STATS_EN adds a fetch_count output counting pushed instructions.
module instr_fetch_unit
   import fetch_defs::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] rom_address,
   output logic        rom_chip_select,
   output logic        rom_output_enable,
   input  logic [63:0] rom_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        halted
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] fetch_count
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;

   logic         fetch;
   logic         zero_word;
   logic         push;
   logic         queue_full;
   logic         queue_empty;
   logic [$clog2(QUEUE_DEPTH):0] queue_count;
   logic         head_valid;
   fetch_entry_t head_data;
   fetch_entry_t push_data;

   // The ROM upper half and the spare queue status flags are intentionally unobserved.
   logic unused_status;
   assign unused_status = ^{rom_data[63:32], queue_empty, queue_count};

   assign fetch     = (state_q == ST_RUN) && !queue_full && !redirect_valid;
   assign zero_word = (rom_data[31:0] == HALT_WORD);
   assign push      = fetch && !zero_word;
   assign push_data = '{pc: pc_q, instr: rom_data[31:0]};

   // NOTE: every signal driven here gets its default first, so no path can leave one
   // unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  if (fetch && zero_word) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase
      if (push) pc_d = pc_q + PC_STEP;
      // Redirect overrides halt, push and the normal PC advance.
      if (redirect_valid) begin
         state_d = ST_RUN;
         pc_d    = align_pc(redirect_pc);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_data  (push_data),
      .pop        (instr_ready),
      .flush      (redirect_valid),
      .full       (queue_full),
      .empty      (queue_empty),
      .count      (queue_count),
      .head_valid (head_valid),
      .head_data  (head_data)
   );

   assign rom_address       = pc_q;
   assign rom_chip_select   = fetch;
   assign rom_output_enable = fetch;
   assign instr_valid       = head_valid;
   assign instr             = head_data.instr;
   assign instr_pc          = head_data.pc;
   assign halted            = (state_q == ST_HALT);

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count_q;

   always_ff @(posedge clock) begin
      if (reset)     fetch_count_q <= '0;
      else if (push) fetch_count_q <= fetch_count_q + 32'd1;
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected {pc, instr} pairs,
// a negedge monitor pops and compares on every accepted decode handshake.
module tb_instr_fetch_unit;

   localparam logic [31:0] W_00 = 32'h9100_1401;  // ADDI
   localparam logic [31:0] W_04 = 32'hF800_03E1;  // STUR
   localparam logic [31:0] W_08 = 32'h9100_0821;  // ADDI
   localparam logic [31:0] W_0C = 32'hF840_03E2;  // LDUR
   localparam logic [31:0] W_F8 = 32'h8B02_0023;  // ADD
   localparam logic [31:0] W_FC = 32'hCB01_0042;  // SUB

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] rom_address;
   logic        rom_chip_select;
   logic        rom_output_enable;
   logic [63:0] rom_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halted;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb [$];

   instr_fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .QUEUE_DEPTH (2)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .rom_address       (rom_address),
      .rom_chip_select   (rom_chip_select),
      .rom_output_enable (rom_output_enable),
      .rom_data          (rom_data),
      .instr_valid       (instr_valid),
      .instr             (instr),
      .instr_pc          (instr_pc),
      .instr_ready       (instr_ready),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .halted            (halted)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count       (fetch_count)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: return W_00;
         32'h0000_0004: return W_04;
         32'h0000_0008: return W_08;
         32'h0000_000C: return W_0C;
         32'hFFFF_FFF8: return W_F8;
         32'hFFFF_FFFC: return W_FC;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   // Undriven bus reads as zero, so any sampling with CS low would look like a halt word.
   always_comb begin
      rom_data = 64'h0;
      if (rom_chip_select) rom_data = {32'hA5A5_5A5A, rom_word(rom_address)};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && !redirect_valid && instr_valid && instr_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_instr: got pc %h instr %h expected nothing", instr_pc, instr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("mon_pc", instr_pc, e.pc);
            check("mon_instr", instr, e.instr);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_seq(input logic [31:0] start_pc, input int n);
      logic [31:0] p;
      p = start_pc;
      for (int i = 0; i < n; i++) begin
         sb.push_back('{pc: p, instr: rom_word(p)});
         p = p + 32'd4;
      end
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      sb.delete();
      tick();
      redirect_valid = 1'b0;
   endtask

   // Restart at 0 with decode stalled; after five cycles the queue holds PCs 0 and 4.
   task automatic fill();
      instr_ready = 1'b0;
      redirect(32'h0000_0000);
      repeat (5) tick();
   endtask

   task automatic run_until_halt(input string name);
      int i;
      for (i = 0; i < 60; i++) begin
         if (halted && sb.size() == 0 && !instr_valid) break;
         tick();
      end
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
      check({name, "_halted"}, {31'd0, halted}, 32'd1);
      check({name, "_halt_pc"}, rom_address, 32'h0000_0010);
      check({name, "_cs_low"}, {31'd0, rom_chip_select}, 32'd0);
      check({name, "_valid_low"}, {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Test 1: reset state, 3-edge latency, straight-line fetch and halt at 0x10.
      reset = 1'b1;
      tick();
      tick();
      check("rst_addr", rom_address, 32'h0000_0000);
      check("rst_cs", {31'd0, rom_chip_select}, 32'd0);
      check("rst_oe", {31'd0, rom_output_enable}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      instr_ready = 1'b1;
      expect_seq(32'h0000_0000, 4);
      reset = 1'b0;
      tick();
      check("boot_cs", {31'd0, rom_chip_select}, 32'd1);
      tick();
      check("lat2_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      check("lat3_valid", {31'd0, instr_valid}, 32'd1);
      check("lat3_pc", instr_pc, 32'h0000_0000);
      run_until_halt("t1");

      // Test 2: stalled decode fills the queue, fetch stops with PC held at 8.
      fill();
      check("t2_cs", {31'd0, rom_chip_select}, 32'd0);
      check("t2_oe", {31'd0, rom_output_enable}, 32'd0);
      check("t2_pc_held", rom_address, 32'h0000_0008);
      check("t2_valid", {31'd0, instr_valid}, 32'd1);
      check("t2_head_pc", instr_pc, 32'h0000_0000);
      check("t2_head_instr", instr, W_00);
      expect_seq(32'h0000_0000, 4);
      instr_ready = 1'b1;
      run_until_halt("t2");

      // Test 3: unaligned redirect to 0xE flushes a full queue and resumes at 0xC.
      fill();
      redirect(32'h0000_000E);
      check("t3_flushed", {31'd0, instr_valid}, 32'd0);
      check("t3_pc", rom_address, 32'h0000_000C);
      expect_seq(32'h0000_000C, 1);
      instr_ready = 1'b1;
      run_until_halt("t3");

      // Test 4: redirect and ready in the same cycle; the flush wins.
      fill();
      instr_ready = 1'b1;
      redirect(32'h0000_0004);
      check("t4_flushed", {31'd0, instr_valid}, 32'd0);
      check("t4_pc", rom_address, 32'h0000_0004);
      expect_seq(32'h0000_0004, 3);
      run_until_halt("t4");

      // Test 5: PC wraps from 0xFFFFFFFC to 0.
      instr_ready = 1'b1;
      redirect(32'hFFFF_FFFB);
      check("t5_pc", rom_address, 32'hFFFF_FFF8);
      check("t5_unhalt", {31'd0, halted}, 32'd0);
      expect_seq(32'hFFFF_FFF8, 6);
      run_until_halt("t5");

      // Test 6: reset with a full queue discards everything.
      fill();
      reset = 1'b1;
      sb.delete();
      tick();
      check("t6_valid", {31'd0, instr_valid}, 32'd0);
      check("t6_addr", rom_address, 32'h0000_0000);
      check("t6_halted", {31'd0, halted}, 32'd0);
      check("t6_cs", {31'd0, rom_chip_select}, 32'd0);
`ifdef FETCH_STATS_EN
      check("t6_fetch_count", fetch_count, 32'd0);
`endif
      reset = 1'b0;
      instr_ready = 1'b1;
      expect_seq(32'h0000_0000, 4);
      run_until_halt("t6");
`ifdef FETCH_STATS_EN
      check("t6_fetch_count_end", fetch_count, 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
